// File: rtl/pipelined_decode_if.sv
// Bundle of the decode stage's upstream, downstream and writeback signals.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer keeps valid and its payload steady until that
// edge. Ready may depend on valid, but valid never waits for ready.
// Upstream: in_valid / in_ready. Downstream: out_valid / out_ready.
// flush and the wb_* signals are unconditioned per-cycle commands.
// dbg_* expose the load-use interlock state for observation only.
interface pipelined_decode_if #(
   parameter int WORD = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic             in_rd_src;
   logic             in_is_load;
   logic             in_reg_write;
   logic             flush;
   logic             wb_en;
   logic [4:0]       wb_reg;
   logic [WORD-1:0]  wb_data;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic [WORD-1:0]  out_read_data1;
   logic [WORD-1:0]  out_read_data2;
   logic [4:0]       out_rd;
   logic             out_is_load;
   logic             out_reg_write;
   logic [2:0]       dbg_stall_cnt;
   logic [4:0]       dbg_stall_rd;
   logic             dbg_hazard;

   // Environment side: drives instructions, writeback, flush and out_ready.
   modport master (
      output in_valid, in_instr, in_rd_src, in_is_load, in_reg_write,
      output flush, wb_en, wb_reg, wb_data, out_ready,
      input  in_ready, out_valid, out_instr, out_read_data1, out_read_data2,
      input  out_rd, out_is_load, out_reg_write,
      input  dbg_stall_cnt, dbg_stall_rd, dbg_hazard
   );

   // Decode stage side.
   modport slave (
      input  in_valid, in_instr, in_rd_src, in_is_load, in_reg_write,
      input  flush, wb_en, wb_reg, wb_data, out_ready,
      output in_ready, out_valid, out_instr, out_read_data1, out_read_data2,
      output out_rd, out_is_load, out_reg_write,
      output dbg_stall_cnt, dbg_stall_rd, dbg_hazard
   );
endinterface

// File: rtl/pipelined_decode.sv
// LEGv8 instruction decode stage: register file with write-through bypass,
// load-use hazard interlock and an ID/EX pipeline register with valid/ready.
module pipelined_decode #(
   parameter int WORD           = 64,
   parameter int NREG           = 32,
   parameter int ZERO_REG       = 31,
   parameter int LOAD_USE_STALL = 1
) (
   input logic               clk,
   input logic               reset,
   pipelined_decode_if.slave bus
);

   localparam logic [4:0]  ZR         = 5'(ZERO_REG);
   localparam logic [2:0]  STALL_INIT = 3'(LOAD_USE_STALL);
   localparam logic [31:0] NREG_U     = 32'(NREG);

   // Index is backed by real storage (not the zero register, not past NREG).
   function automatic logic reg_backed(input logic [4:0] idx);
      return (idx != ZR) && ({27'b0, idx} < NREG_U);
   endfunction

   logic [WORD-1:0] regs_q [NREG];

   logic [4:0]      rn;
   logic [4:0]      rm;
   logic [4:0]      rd;
   logic [4:0]      read_reg2;
   logic [WORD-1:0] read_data1;
   logic [WORD-1:0] read_data2;

   logic            out_valid_q, out_valid_d;
   logic [31:0]     out_instr_q, out_instr_d;
   logic [WORD-1:0] out_rd1_q, out_rd1_d;
   logic [WORD-1:0] out_rd2_q, out_rd2_d;
   logic [4:0]      out_rd_q, out_rd_d;
   logic            out_is_load_q, out_is_load_d;
   logic            out_reg_write_q, out_reg_write_d;

   logic [2:0]      stall_cnt_q, stall_cnt_d;
   logic [4:0]      stall_rd_q, stall_rd_d;

   logic            hazard;
   logic            in_ready;
   logic            accept;
   logic            load_handoff;

   assign rn        = bus.in_instr[9:5];
   assign rm        = bus.in_instr[20:16];
   assign rd        = bus.in_instr[4:0];
   assign read_reg2 = bus.in_rd_src ? rd : rm;

   // Tracked destination t collides with a source of the offered instruction.
   function automatic logic depends_on(input logic [4:0] t);
      return (t != ZR) && ((t == rn) || (t == read_reg2));
   endfunction

   // Combinational reads; a same-cycle writeback is forwarded to the reader.
   always_comb begin
      read_data1 = '0;
      read_data2 = '0;
      if (reg_backed(rn)) begin
         read_data1 = (bus.wb_en && (bus.wb_reg == rn)) ? bus.wb_data : regs_q[rn];
      end
      if (reg_backed(read_reg2)) begin
         read_data2 = (bus.wb_en && (bus.wb_reg == read_reg2)) ? bus.wb_data : regs_q[read_reg2];
      end
   end

   // Load-use interlock: load still in ID/EX, or in its post-handoff shadow.
   always_comb begin
      hazard       = (out_valid_q && out_is_load_q && out_reg_write_q && depends_on(out_rd_q))
                   || ((stall_cnt_q != 3'd0) && depends_on(stall_rd_q));
      in_ready     = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
      accept       = bus.in_valid && in_ready;
      load_handoff = out_valid_q && bus.out_ready && out_is_load_q && out_reg_write_q;
   end

   // Next state of the ID/EX register and the interlock shadow counter.
   always_comb begin
      out_valid_d     = out_valid_q;
      out_instr_d     = out_instr_q;
      out_rd1_d       = out_rd1_q;
      out_rd2_d       = out_rd2_q;
      out_rd_d        = out_rd_q;
      out_is_load_d   = out_is_load_q;
      out_reg_write_d = out_reg_write_q;
      stall_cnt_d     = stall_cnt_q;
      stall_rd_d      = stall_rd_q;

      if (bus.flush) begin
         out_valid_d = 1'b0;
         stall_cnt_d = 3'd0;
      end else begin
         if (accept) begin
            out_valid_d     = 1'b1;
            out_instr_d     = bus.in_instr;
            out_rd1_d       = read_data1;
            out_rd2_d       = read_data2;
            out_rd_d        = rd;
            out_is_load_d   = bus.in_is_load;
            out_reg_write_d = bus.in_reg_write;
         end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
         end

         if (load_handoff) begin
            stall_cnt_d = STALL_INIT;
            stall_rd_d  = out_rd_q;
         end else if (stall_cnt_q != 3'd0) begin
            stall_cnt_d = stall_cnt_q - 3'd1;
         end
      end
   end

   // Register file storage; the zero register and out-of-range writes are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (bus.wb_en && reg_backed(bus.wb_reg)) begin
         regs_q[bus.wb_reg] <= bus.wb_data;
      end
   end

   // ID/EX pipeline register and interlock state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q     <= 1'b0;
         out_instr_q     <= '0;
         out_rd1_q       <= '0;
         out_rd2_q       <= '0;
         out_rd_q        <= '0;
         out_is_load_q   <= 1'b0;
         out_reg_write_q <= 1'b0;
         stall_cnt_q     <= '0;
         stall_rd_q      <= '0;
      end else begin
         out_valid_q     <= out_valid_d;
         out_instr_q     <= out_instr_d;
         out_rd1_q       <= out_rd1_d;
         out_rd2_q       <= out_rd2_d;
         out_rd_q        <= out_rd_d;
         out_is_load_q   <= out_is_load_d;
         out_reg_write_q <= out_reg_write_d;
         stall_cnt_q     <= stall_cnt_d;
         stall_rd_q      <= stall_rd_d;
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_instr      = out_instr_q;
   assign bus.out_read_data1 = out_rd1_q;
   assign bus.out_read_data2 = out_rd2_q;
   assign bus.out_rd         = out_rd_q;
   assign bus.out_is_load    = out_is_load_q;
   assign bus.out_reg_write  = out_reg_write_q;
   assign bus.dbg_stall_cnt  = stall_cnt_q;
   assign bus.dbg_stall_rd   = stall_rd_q;
   assign bus.dbg_hazard     = hazard;

endmodule
